// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if: request/release inputs and registered decoder-drive outputs of the round-robin arbiter
interface rr_decode_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       hold_off;
  logic [1:0] sel;
  logic       dec_dis;
  logic [3:0] gnt;
  logic       preempt;
  modport master (input req, done, hold_off, output sel, dec_dis, gnt, preempt);
  modport slave  (output req, done, hold_off, input sel, dec_dis, gnt, preempt);
endinterface

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin sequencer driving a shared 2-to-4 decoder select and disable.
// Define RR_FORCE_RELEASE_EN to cap each grant at MAX_HOLD cycles and report it on preempt.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_decode_arbiter_if.master   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t     state, nextState;
  logic [1:0] ptr, nextPtr, pick, nextSel;
  logic [3:0] nextGnt;
  logic       nextDecDis, nextPreempt, userRel, timeout;
`ifdef RR_FORCE_RELEASE_EN
  logic [7:0] holdCnt;
  always_ff @(posedge clk)
    if (!rst_n) holdCnt <= 8'd0;
    else holdCnt <= (state == BUSY) ? holdCnt + 8'd1 : 8'd0;
  assign timeout = (state == BUSY) && (holdCnt == 8'(MAX_HOLD - 1));
`else
  assign timeout = (MAX_HOLD == 0);
`endif
  assign userRel = bus.done || !bus.req[bus.sel] || bus.hold_off;
  // First requester at or after ptr, wrapping; lowest offset wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--)
      if (bus.req[ptr + 2'(i)]) pick = ptr + 2'(i);
  end
  always_comb begin
    nextState   = state;
    nextPtr     = ptr;
    nextSel     = bus.sel;
    nextGnt     = bus.gnt;
    nextDecDis  = bus.dec_dis;
    nextPreempt = 1'b0;
    case (state)
      IDLE:
        if (!bus.hold_off && |bus.req) begin
          nextState  = BUSY;
          nextSel    = pick;
          nextGnt    = 4'b0001 << pick;
          nextDecDis = 1'b0;
        end
      BUSY:
        if (userRel || timeout) begin
          nextState   = GAP;
          nextGnt     = 4'b0000;
          nextDecDis  = 1'b1;
          nextPtr     = bus.sel + 2'd1;
          nextPreempt = timeout && !userRel;
        end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      bus.sel     <= 2'd0;
      bus.gnt     <= 4'b0000;
      bus.dec_dis <= 1'b1;
      bus.preempt <= 1'b0;
    end else begin
      state       <= nextState;
      ptr         <= nextPtr;
      bus.sel     <= nextSel;
      bus.gnt     <= nextGnt;
      bus.dec_dis <= nextDecDis;
      bus.preempt <= nextPreempt;
    end
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed plan steps plus random traffic against a grant-level reference model
module tb_rr_decode_arbiter;
  localparam int MAX_HOLD = 4;
`ifdef RR_FORCE_RELEASE_EN
  localparam bit FORCE = 1'b1;
`else
  localparam bit FORCE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstN;
  int checks = 0;
  int failures = 0;
  int grantee, gapLeft, mPtr, mSel, held, mPreempt;
  int order[$];
  rr_decode_arbiter_if bus();
  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rstN), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic [3:0] r, input logic d, input logic h, input logic rn);
    bit user, to;
    if (!rn) begin
      grantee = -1; gapLeft = 0; mPtr = 0; mSel = 0; held = 0; mPreempt = 0;
      return;
    end
    mPreempt = 0;
    if (grantee >= 0) begin
      user = d || !r[grantee] || h;
      to = FORCE && held >= MAX_HOLD;
      if (user || to) begin
        mPreempt = to && !user;
        mPtr = (grantee + 1) % 4;
        grantee = -1;
        gapLeft = 1;
      end else held++;
    end else if (gapLeft > 0) gapLeft = 0;
    else if (!h && r != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (grantee < 0 && r[(mPtr + i) % 4]) grantee = (mPtr + i) % 4;
      mSel = grantee;
      held = 1;
      order.push_back(grantee);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d, input logic h, input logic rn);
    bus.req = r; bus.done = d; bus.hold_off = h; rstN = rn;
    @(posedge clk);
    modelEdge(r, d, h, rn);
    #1;
    check("gnt", 32'(bus.gnt), grantee >= 0 ? 32'(1 << grantee) : 32'd0);
    check("sel", 32'(bus.sel), 32'(mSel));
    check("dec_dis", 32'(bus.dec_dis), grantee < 0 ? 32'd1 : 32'd0);
    check("preempt", 32'(bus.preempt), 32'(mPreempt));
  endtask

  initial begin
    int r;
    grantee = -1; gapLeft = 0; mPtr = 0; mSel = 0; held = 0; mPreempt = 0;
    bus.req = 4'b0; bus.done = 1'b0; bus.hold_off = 1'b0; rstN = 1'b0;
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    check("reset_dec_dis", 32'(bus.dec_dis), 32'd1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 1, 0, 1);
    // single grant to requester 2, done three cycles later
    step(4'b0100, 0, 0, 1);
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_sel", 32'(bus.sel), 32'd2);
    step(4'b0100, 0, 0, 1);
    step(4'b0100, 0, 0, 1);
    step(4'b0100, 1, 0, 1);
    check("single_release", 32'(bus.dec_dis), 32'd1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    // all requesting: rotation continues from ptr=3 and wraps
    order.delete();
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 0, 0, 1);
      step(4'b1111, 1, 0, 1);
      step(4'b1111, 0, 0, 1);
    end
    check("rot_count", 32'(order.size()), 32'd5);
    if (order.size() == 5) begin
      check("rot0", 32'(order[0]), 32'd3);
      check("rot1", 32'(order[1]), 32'd0);
      check("rot2", 32'(order[2]), 32'd1);
      check("rot3", 32'(order[3]), 32'd2);
      check("rot4", 32'(order[4]), 32'd3);
    end
    // hold_off with done on the same cycle
    step(4'b0000, 0, 0, 0);
    step(4'b0010, 0, 0, 1);
    check("ho_gnt1", 32'(bus.gnt), 32'h2);
    step(4'b0110, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(4'b0110, 0, 1, 1);
    check("ho_blocked", 32'(bus.gnt), 32'h0);
    step(4'b0110, 0, 0, 1);
    check("ho_gnt2", 32'(bus.gnt), 32'h4);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    // held request with no done: forced release when compiled in
    for (int i = 0; i < 14; i++) step(4'b0001, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 1);
    // reset mid-grant with sel=3
    step(4'b1000, 0, 0, 1);
    check("mid_sel3", 32'(bus.sel), 32'd3);
    step(4'b1001, 0, 0, 0);
    check("mid_rst_sel", 32'(bus.sel), 32'd0);
    step(4'b1001, 0, 0, 1);
    check("mid_next_gnt", 32'(bus.gnt), 32'h1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      step(4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, r != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
